// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//
// Purpose:
//   CPU architectural register file with R0..R31.
//   - R0 is hard-wired to zero on every port.
//   - One general write port is provided.
//   - A dedicated link write port always targets R31. When both ports hit
//     R31 on the same edge, the link write wins.
//   - Two combinational read ports (rs, rt) use write-through bypass.
//   - A debug read port (dbg) shows stored contents only and is never
//     bypassed.
//
// Ports:
//   clk        in   1      sole clock, rising-edge active
//   rst        in   1      synchronous active-high reset, clears all registers
//   rs_addr    in   5      read port A index
//   rt_addr    in   5      read port B index
//   rs_data    out  WIDTH  read port A data (bypassed)
//   rt_data    out  WIDTH  read port B data (bypassed)
//   wr_en      in   1      general write enable
//   wr_addr    in   5      general write index
//   wr_data    in   WIDTH  general write data
//   link_en    in   1      link write enable (targets R31)
//   link_data  in   WIDTH  link write data (return address)
//   dbg_addr   in   5      debug read index
//   dbg_data   out  WIDTH  debug read data (stored contents only)
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] rt_data,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             link_en,
    input  logic [WIDTH-1:0] link_data,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam logic [4:0] LINK_REG = 5'd31;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    // A general write to R0 is squashed here, so R0 never holds anything but
    // zero. The link write is applied after the general write, which makes
    // link_data win when both ports target R31.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en && (wr_addr != ZERO_REG)) begin
            regs_d[wr_addr] = wr_data;
        end
        if (link_en) begin
            regs_d[LINK_REG] = link_data;
        end
    end

    // Reset has priority over every write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A. Index 0 is forced to zero so the port also reads zero
    // before the first reset. Bypass is suppressed while in reset because
    // the pending write will be discarded.
    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == ZERO_REG) begin
            rs_data = '0;
        end else if (!rst && link_en && (rs_addr == LINK_REG)) begin
            rs_data = link_data;
        end else if (!rst && wr_en && (rs_addr == wr_addr)) begin
            rs_data = wr_data;
        end
    end

    // Read port B uses the same selection as port A, so both ports return
    // identical data for the same index.
    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == ZERO_REG) begin
            rt_data = '0;
        end else if (!rst && link_en && (rt_addr == LINK_REG)) begin
            rt_data = link_data;
        end else if (!rst && wr_en && (rt_addr == wr_addr)) begin
            rt_data = wr_data;
        end
    end

    // The debug port shows only committed contents.
    always_comb begin
        dbg_data = regs_q[dbg_addr];
        if (dbg_addr == ZERO_REG) begin
            dbg_data = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//
// Scoreboard bench for reg_file.
//   - The stimulus process drives one vector per clock cycle, just after the
//     rising edge.
//   - With each vector it pushes the hand-computed expected read values into
//     a queue.
//   - The monitor samples at the falling edge, while the vector is stable and
//     before the edge that commits it.
//   - On each sample it pops one entry and compares rs/rt/dbg under the
//     entry's check mask.
// ---------------------------------------------------------------------------
module tb_reg_file;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             link_en;
    logic [WIDTH-1:0] link_data;
    logic [4:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    typedef struct {
        string            name;
        logic [2:0]       mask;
        logic [WIDTH-1:0] exp_rs;
        logic [WIDTH-1:0] exp_rt;
        logic [WIDTH-1:0] exp_dbg;
    } exp_t;

    exp_t exp_q[$];
    logic chk_valid;
    int   checks;
    int   errors;

    // Mask bits: 2 = rs, 1 = rt, 0 = dbg
    localparam logic [2:0] ALL    = 3'b111;
    localparam logic [2:0] RS     = 3'b100;
    localparam logic [2:0] RT     = 3'b010;
    localparam logic [2:0] DBG    = 3'b001;
    localparam logic [2:0] RS_RT  = 3'b110;
    localparam logic [2:0] RT_DBG = 3'b011;

    reg_file #(
        .WIDTH(WIDTH),
        .DEPTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .link_en(link_en),
        .link_data(link_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    // 10 time-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one port value and record the result
    task automatic checkOutput(input string name, input string port,
                               input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s got 0x%08h expected 0x%08h", name, port, actual, expected);
        end
    endtask

    // Monitor: pops one expectation per sampled cycle
    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_underflow got 0 entries expected 1");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.mask[2]) checkOutput(e.name, "rs",  rs_data,  e.exp_rs);
                if (e.mask[1]) checkOutput(e.name, "rt",  rt_data,  e.exp_rt);
                if (e.mask[0]) checkOutput(e.name, "dbg", dbg_data, e.exp_dbg);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected reads for that cycle
    task automatic applyStimulus(input string name,
                                 input logic r,
                                 input logic we, input logic [4:0] wa, input logic [WIDTH-1:0] wd,
                                 input logic le, input logic [WIDTH-1:0] ld,
                                 input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da,
                                 input logic [2:0] mask,
                                 input logic [WIDTH-1:0] ers, input logic [WIDTH-1:0] ert,
                                 input logic [WIDTH-1:0] edbg);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        link_en   = le;
        link_data = ld;
        rs_addr   = ra;
        rt_addr   = rb;
        dbg_addr  = da;
        e.name    = name;
        e.mask    = mask;
        e.exp_rs  = ers;
        e.exp_rt  = ert;
        e.exp_dbg = edbg;
        exp_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        chk_valid = 1'b0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        link_en   = 1'b0;
        link_data = '0;
        rs_addr   = '0;
        rt_addr   = '0;
        dbg_addr  = '0;

        // First reset edge clears the array. A write is presented but must be
        // neither bypassed nor committed.
        applyStimulus("rst_first", 1, 1, 5'd3, 32'h99, 0, 0, 5'd0, 5'd0, 5'd0,
                      ALL, 0, 0, 0);
        applyStimulus("rst_nobypass", 1, 1, 5'd3, 32'h99, 1, 32'h44, 5'd3, 5'd31, 5'd3,
                      ALL, 0, 0, 0);

        // All 32 registers read zero after reset on every port
        for (int i = 0; i < 32; i++) begin
            applyStimulus("reset_sweep", 0, 0, 5'd0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i),
                          ALL, 0, 0, 0);
        end

        // Write-through bypass on rs; dbg still shows the old value
        applyStimulus("bypass_r5", 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd5, 5'd0, 5'd5,
                      ALL, 32'hDEADBEEF, 0, 0);
        applyStimulus("commit_r5", 0, 0, 5'd0, 0, 0, 0, 5'd5, 5'd5, 5'd5,
                      ALL, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);

        // Writes to R0 are dropped, including bypass
        applyStimulus("r0_write", 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, 5'd0, 5'd0, 5'd0,
                      ALL, 0, 0, 0);
        applyStimulus("r0_after", 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd0, 5'd0,
                      ALL, 0, 0, 0);

        // Link beats a general write to R31
        applyStimulus("link_win", 0, 1, 5'd31, 32'h12345678, 1, 32'h40, 5'd31, 5'd31, 5'd31,
                      ALL, 32'h40, 32'h40, 0);
        applyStimulus("link_win_after", 0, 0, 5'd0, 0, 0, 0, 5'd5, 5'd31, 5'd31,
                      ALL, 32'hDEADBEEF, 32'h40, 32'h40);

        // Link plus a general write elsewhere: both commit together
        applyStimulus("dual_write", 0, 1, 5'd7, 32'hA5A5A5A5, 1, 32'h100, 5'd7, 5'd31, 5'd31,
                      ALL, 32'hA5A5A5A5, 32'h100, 32'h40);
        applyStimulus("dual_after", 0, 0, 5'd0, 0, 0, 0, 5'd7, 5'd31, 5'd7,
                      ALL, 32'hA5A5A5A5, 32'h100, 32'hA5A5A5A5);

        // General write to R31 without link
        applyStimulus("wr_r31", 0, 1, 5'd31, 32'h31313131, 0, 0, 5'd31, 5'd31, 5'd31,
                      ALL, 32'h31313131, 32'h31313131, 32'h100);
        applyStimulus("wr_r31_after", 0, 0, 5'd0, 0, 0, 0, 5'd0, 5'd31, 5'd31,
                      RT_DBG, 0, 32'h31313131, 32'h31313131);

        // Load R9, then reset with a write to R9 pending
        applyStimulus("load_r9", 0, 1, 5'd9, 32'h55, 0, 0, 5'd9, 5'd9, 5'd9,
                      ALL, 32'h55, 32'h55, 0);
        applyStimulus("rst_mid_1", 1, 1, 5'd9, 32'h77, 1, 32'h88, 5'd0, 5'd0, 5'd9,
                      DBG, 0, 0, 32'h55);
        applyStimulus("rst_mid_2", 1, 1, 5'd9, 32'h77, 1, 32'h88, 5'd9, 5'd31, 5'd9,
                      ALL, 0, 0, 0);
        applyStimulus("rst_released", 0, 0, 5'd0, 0, 0, 0, 5'd7, 5'd31, 5'd9,
                      ALL, 0, 0, 0);

        // First write after reset release commits on the next edge
        applyStimulus("post_rst_wr", 0, 1, 5'd12, 32'h0BADF00D, 0, 0, 5'd12, 5'd12, 5'd12,
                      ALL, 32'h0BADF00D, 32'h0BADF00D, 0);
        applyStimulus("post_rst_after", 0, 0, 5'd0, 0, 0, 0, 5'd12, 5'd12, 5'd12,
                      ALL, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D);

        // Link-only write with bypass on rs
        applyStimulus("link_only", 0, 0, 5'd0, 0, 1, 32'h0000CAFE, 5'd31, 5'd12, 5'd31,
                      ALL, 32'h0000CAFE, 32'h0BADF00D, 0);
        applyStimulus("link_only_after", 0, 0, 5'd0, 0, 0, 0, 5'd31, 5'd31, 5'd31,
                      ALL, 32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE);

        // Bypass on rt only; rs sees an unrelated stored register
        applyStimulus("bypass_rt", 0, 1, 5'd20, 32'h13579BDF, 0, 0, 5'd7, 5'd20, 5'd20,
                      ALL, 0, 32'h13579BDF, 0);
        applyStimulus("bypass_rt_after", 0, 0, 5'd0, 0, 0, 0, 5'd20, 5'd20, 5'd0,
                      RS_RT, 32'h13579BDF, 32'h13579BDF, 0);

        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        wr_en     = 1'b0;
        link_en   = 1'b0;

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
